// File: rtl/nv_ram_rwsp_param.sv
// nv_ram_rwsp_param: parametrised 1R1W synchronous RAM.
//  - registered read address (ra_d) plus independently enabled output register
//  - optional post-reset zero sweep (INIT_EN) with init_done indication
//  - dout_vld marks dout as holding data from a completed read
// Optional feature macro: NV_RAM_RWSP_PARITY_EN
//  - defined:   each entry stores an extra even-parity bit; dout_perr flags a
//               parity mismatch on every output-register load
//  - undefined: array is WIDTH bits wide and dout_perr is tied low
module nv_ram_rwsp_param #(
  parameter int unsigned WIDTH   = 289,
  parameter int unsigned DEPTH   = 20,
  parameter int unsigned AW      = 5,
  parameter int unsigned INIT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_done,
  output logic             dout_perr,
  input  logic [31:0]      pwrbus_ram_pd
);

`ifdef NV_RAM_RWSP_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  // Depth/last-index constants sized to the address path so that range
  // compares are exact even when DEPTH == 2^AW.
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;

  logic [MW-1:0]   mem [DEPTH];

  logic [AW-1:0]   ra_d;
  logic            rd_pend;

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [MW-1:0]   mem_wd;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   rd_word;
  logic            wa_in_range;
  logic            ra_in_range;
  logic            ready;

  // The power-down bus has no functional effect.
  logic            unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;

  assign ready       = (state == ST_READY);
  assign wa_in_range = ({1'b0, wa}   < DEPTH_EXT);
  assign ra_in_range = ({1'b0, ra_d} < DEPTH_EXT);

`ifdef NV_RAM_RWSP_PARITY_EN
  assign wr_word = {^di, di};
`else
  assign wr_word = di;
`endif

  // Init controller: sweep counter and READY transition; init_done registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      init_done <= (INIT_EN == 0);
      cnt       <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_READY: begin
          state <= ST_READY;
        end
        default: begin
          state <= ST_READY;
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the port during INIT, the user port afterwards.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wr_word;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else if (we && wa_in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array; not reset, cleaned by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Asynchronous array read through the registered address; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (ra_in_range) begin
      rd_word = mem[ra_d];
    end
  end

  // Read pipeline: address capture on re, output register load on ore.
  // rd_pend is set by re and consumed by ore; a simultaneous re re-arms it
  // so back-to-back reads keep one word per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_d     <= '0;
      rd_pend  <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (ready) begin
      if (re) begin
        ra_d <= ra;
      end
      if (ore) begin
        dout     <= rd_word[WIDTH-1:0];
        dout_vld <= rd_pend;
      end
      if (re) begin
        rd_pend <= 1'b1;
      end else if (ore) begin
        rd_pend <= 1'b0;
      end
    end
  end

`ifdef NV_RAM_RWSP_PARITY_EN
  // Parity check on each output-register load; held while ore is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_perr <= 1'b0;
    end else if (ready && ore) begin
      dout_perr <= (^rd_word[WIDTH-1:0]) != rd_word[WIDTH];
    end
  end
`else
  assign dout_perr = 1'b0;
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Testbench for nv_ram_rwsp_param: randomized + directed stimulus, reference
// model produces one expected output snapshot per clock into a queue, and an
// independent monitor pops and compares against the DUT each cycle.
module tb_nv_ram_rwsp_param;
  localparam int unsigned WIDTH = 289;
  localparam int unsigned DEPTH = 20;
  localparam int unsigned AW    = 5;
`ifdef NV_RAM_RWSP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    ra;
  logic             re;
  logic             ore;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    wa;
  logic             we;
  logic [WIDTH-1:0] di;
  logic             init_done;
  logic             dout_perr;
  logic [31:0]      pwrbus_ram_pd;

  always #5 clk = ~clk;

  nv_ram_rwsp_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW(AW),
    .INIT_EN(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ra(ra),
    .re(re),
    .ore(ore),
    .dout(dout),
    .dout_vld(dout_vld),
    .wa(wa),
    .we(we),
    .di(di),
    .init_done(init_done),
    .dout_perr(dout_perr),
    .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             vld;
    logic             idone;
    logic             perr;
  } exp_t;

  exp_t expq[$];

  // Reference model state: contents as a plain array, read request as
  // an integer address plus "a read is outstanding" flag.
  logic [WIDTH-1:0] m    [DEPTH];
  bit               mpar [DEPTH];
  int unsigned      init_left;
  int unsigned      m_addr;
  bit               m_pend;
  logic [WIDTH-1:0] m_dout;
  bit               m_vld;
  bit               m_perr;

  task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [WIDTH-1:0] old;
    bit               oldpar;
    exp_t             e;
    if (reset) begin
      init_left = DEPTH;
      m_addr    = 0;
      m_pend    = 0;
      m_dout    = '0;
      m_vld     = 0;
      m_perr    = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m[i]    = '0;
        mpar[i] = 0;
      end
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      old    = (m_addr < DEPTH) ? m[m_addr] : '0;
      oldpar = (m_addr < DEPTH) ? mpar[m_addr] : 1'b0;
      if (ore) begin
        m_dout = old;
        m_vld  = m_pend;
        m_pend = 0;
        m_perr = PAR_EN && ((^old) != oldpar);
      end
      if (re) begin
        m_addr = int'(ra);
        m_pend = 1;
      end
      if (we && int'(wa) < DEPTH) begin
        m[int'(wa)]    = di;
        mpar[int'(wa)] = ^di;
      end
    end
    e.dout  = m_dout;
    e.vld   = m_vld;
    e.idone = (init_left == 0);
    e.perr  = m_perr;
    expq.push_back(e);
  endtask

  task automatic cycle(input bit r_rst, input bit r_re, input int r_ra, input bit r_we,
                       input int r_wa, input logic [WIDTH-1:0] r_di, input bit r_ore);
    @(negedge clk);
    reset = r_rst;
    re    = r_re;
    ra    = AW'(r_ra);
    we    = r_we;
    wa    = AW'(r_wa);
    di    = r_di;
    ore   = r_ore;
    pwrbus_ram_pd = $urandom;
    @(posedge clk);
    model_step();
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w = (w << 32) | WIDTH'($urandom);
    return w;
  endfunction

  task automatic rnd_cycle(input bit r_rst);
    int a;
    int b;
    a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 31)) : int'($urandom_range(0, DEPTH - 1));
    b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 31)) : int'($urandom_range(0, DEPTH - 1));
    cycle(r_rst, 1'($urandom), a, 1'($urandom), b, rnd_word(), 1'($urandom));
  endtask

  // Monitor: every cycle the DUT presents a new output snapshot, compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chkw("dout", dout, e.dout);
        chk1("dout_vld", dout_vld, e.vld);
        chk1("init_done", init_done, e.idone);
        chk1("dout_perr", dout_perr, e.perr);
      end
    end
  end

  initial begin
    reset = 1'b1; re = 1'b0; ore = 1'b0; we = 1'b0;
    ra = '0; wa = '0; di = '0; pwrbus_ram_pd = '0;

    cycle(1, 0, 0, 0, 0, '0, 0);
    #1;
    chk1("reset_init_done", init_done, 1'b0);
    chkw("reset_dout", dout, '0);

    // Sweep with random traffic that must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      rnd_cycle(0);
      #1;
      chk1("sweep_init_done", init_done, (i == DEPTH - 1));
      chkw("sweep_dout_held", dout, '0);
    end

    // Every entry reads back zero after the sweep.
    for (int a = 0; a < DEPTH; a++) begin
      cycle(0, 1, a, 0, 0, '0, 0);
      cycle(0, 0, 0, 0, 0, '0, 1);
      #1;
      chkw("swept_zero", dout, '0);
      chk1("swept_vld", dout_vld, 1'b1);
    end

    // Basic read with held output.
    cycle(0, 0, 0, 1, 3, WIDTH'(32'h1234), 0);
    cycle(0, 1, 3, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chkw("basic_read", dout, WIDTH'(32'h1234));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 3, rnd_word(), 0);
      #1;
      chkw("basic_hold", dout, WIDTH'(32'h1234));
    end

    // Collisions on address 5.
    cycle(0, 0, 0, 1, 5, WIDTH'(4'hA), 0);
    cycle(0, 1, 5, 1, 5, WIDTH'(4'hB), 0);
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chkw("coll_write_first", dout, WIDTH'(4'hB));
    cycle(0, 1, 5, 0, 0, '0, 0);
    cycle(0, 0, 0, 1, 5, WIDTH'(4'hC), 1);
    #1;
    chkw("coll_old_data", dout, WIDTH'(4'hB));
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chkw("coll_new_after", dout, WIDTH'(4'hC));
    chk1("coll_vld_consumed", dout_vld, 1'b0);

    // Out-of-range write and read.
    cycle(0, 0, 0, 1, 25, rnd_word(), 0);
    cycle(0, 1, 25, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chkw("oor_read", dout, '0);
    for (int a = 0; a < DEPTH; a++) begin
      cycle(0, 1, a, 0, 0, '0, 1);
    end
    cycle(0, 0, 0, 0, 0, '0, 1);

    // Back-to-back and random traffic.
    for (int i = 0; i < 1500; i++) rnd_cycle(0);

    // Reset in the middle of a sweep restarts it.
    cycle(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) rnd_cycle(0);
    cycle(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rnd_cycle(0);
      #1;
      chk1("restart_init_done", init_done, (i == DEPTH - 1));
      chkw("restart_dout_zero", dout, '0);
    end

`ifdef NV_RAM_RWSP_PARITY_EN
    cycle(0, 0, 0, 1, 1, WIDTH'(8'hFF), 0);
    cycle(0, 0, 0, 1, 2, WIDTH'(8'h7F), 0);
    #1;
    dut.mem[1][WIDTH] = ~dut.mem[1][WIDTH];
    mpar[1] = ~mpar[1];
    cycle(0, 1, 1, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chk1("parity_corrupt", dout_perr, 1'b1);
    cycle(0, 1, 2, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1);
    #1;
    chk1("parity_clean", dout_perr, 1'b0);
`endif

    for (int i = 0; i < 300; i++) rnd_cycle(0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, '0, 0);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
